uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_W, default 8, number of data bits per frame (5..9).
REQ-002 Parameter: STOP_BITS, default 1, number of stop-bit intervals (1 or 2).
REQ-003 Parameter: PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined.
REQ-004 clk  input  1  single system clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 baud_tick  input  1  one-cycle strobe marking a bit-interval boundary.
REQ-007 tx_valid  input  1  tx_data holds a byte to send.
REQ-008 tx_data  input  DATA_W  parallel data word, sampled only on accept.
REQ-009 tx_ready  output  1  block can accept a word this cycle.
REQ-010 tx_o  output  1  serial line, registered, idle high.
REQ-011 tx_busy  output  1  frame pending or in progress.
REQ-012 tx_done  output  1  one-cycle pulse at end of final stop bit.

Function
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; every non-IDLE state advances only on a cycle with baud_tick=1.
REQ-014 Accept SHALL occur when tx_valid=1 and tx_ready=1; tx_data latches into a shift register and a pending flag is set.
REQ-015 tx_ready SHALL be 1 only in IDLE with no pending word; tx_valid at any other time is ignored with no side effect.
REQ-016 IDLE with pending set SHALL go to START on the first baud_tick strictly after the accept cycle; a tick coinciding with accept does not start the frame.
REQ-017 tx_o SHALL update on the clock edge sampling baud_tick=1, so each bit is held exactly one tick-to-tick interval.
REQ-018 START drives tx_o=0; on baud_tick go to DATA, bit counter cleared, tx_o = shift[0].
REQ-019 DATA sends LSB first; on each tick, shift right, counter+1; on tick with counter = DATA_W-1 go to PARITY (macro defined) else STOP.
REQ-020 PARITY drives tx_o = XOR of latched data, inverted when PARITY_ODD=1; on tick go to STOP.
REQ-021 STOP drives tx_o=1 for STOP_BITS intervals; on final tick assert tx_done for that one cycle, clear pending, return to IDLE.
REQ-022 tx_ready SHALL rise in the cycle after tx_done, allowing back-to-back frames with no idle interval beyond the wait for the next tick.
REQ-023 tx_busy SHALL be 1 whenever pending is set or state is not IDLE.
REQ-024 Counter SHALL be wide enough for DATA_W-1 and never wrap mid-frame; illegal state encodings return to IDLE with tx_o=1.

Reset
REQ-025 On a clock edge with rst=1: state=IDLE, tx_o=1, tx_ready=1, tx_busy=0, tx_done=0, counter=0, shift register=0, pending=0.
REQ-026 rst SHALL override baud_tick and tx_valid in the same cycle; reset mid-frame aborts with no tx_done and tx_o=1 the following cycle.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: PARITY state and parity bit compiled in, frame = 1+DATA_W+1+STOP_BITS intervals.
REQ-028 Macro undefined: PARITY state and parity logic absent, DATA goes directly to STOP, frame = 1+DATA_W+STOP_BITS intervals, PARITY_ODD ignored.

Verification
REQ-029 No macro, DATA_W=8, send 0xA5 -> tx_o per interval 0,1,0,1,0,0,1,0,1,1; tx_done one cycle on 10th tick.
REQ-030 Macro, even, send 0x07 -> parity interval tx_o=1; PARITY_ODD=1 send 0x00 -> parity interval tx_o=1.
REQ-031 tx_valid and baud_tick high same cycle in IDLE -> word accepted, tx_o stays 1 until the next tick, then 0.
REQ-032 tx_valid held with 0x3C then 0xC3 during frame -> 0x3C sent intact, 0xC3 accepted only after tx_done, second START on the next tick.
REQ-033 rst=1 during DATA bit 4 -> next cycle tx_o=1, tx_ready=1, tx_busy=0, no tx_done pulse.
REQ-034 STOP_BITS=2, send 0xFF -> tx_o high for 2 intervals after last data bit; tx_done only on second stop tick.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (PARITY_ODD then selects odd/even).
module uart_tx #(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_o,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , PARITY = 3'd4
`endif
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              stop_cnt, stop_cnt_n;
    logic              pending, pending_n;
    logic              line, line_n;
    logic              done;
`ifdef UART_TX_PARITY_EN
    logic              par, par_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            cnt      <= '0;
            stop_cnt <= 1'b0;
            pending  <= 1'b0;
            line     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            cnt      <= cnt_n;
            stop_cnt <= stop_cnt_n;
            pending  <= pending_n;
            line     <= line_n;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    // The line value for the next bit interval is registered on the ticking edge,
    // so every bit is held for exactly one tick-to-tick interval.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        cnt_n      = cnt;
        stop_cnt_n = stop_cnt;
        pending_n  = pending;
        line_n     = line;
        done       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n      = par;
`endif
        case (state)
            IDLE: begin
                line_n = 1'b1;
                if (tx_valid && !pending) begin
                    shift_n   = tx_data;
                    pending_n = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_n     = (^tx_data) ^ PARITY_ODD;
`endif
                end else if (pending && baud_tick) begin
                    state_n = START;
                    line_n  = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    line_n  = shift[0];
                    shift_n = shift >> 1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (cnt == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_n    = PARITY;
                        line_n     = par;
`else
                        state_n    = STOP;
                        stop_cnt_n = 1'b0;
                        line_n     = 1'b1;
`endif
                    end else begin
                        cnt_n   = cnt + 1'b1;
                        line_n  = shift[0];
                        shift_n = shift >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                    line_n     = 1'b1;
                end
            end
`endif
            STOP: begin
                line_n = 1'b1;
                if (baud_tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        done      = 1'b1;
                        pending_n = 1'b0;
                        state_n   = IDLE;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                line_n    = 1'b1;
                pending_n = 1'b0;
            end
        endcase
    end

    // tx_done marks the ticking cycle itself; pending clears on that edge, so ready follows a cycle later.
    assign tx_done  = done && !rst;
    assign tx_ready = (state == IDLE) && !pending;
    assign tx_busy  = pending || (state != IDLE);
    assign tx_o     = line;

endmodule
